// File: rtl/vliw_mem_access_unit.sv
// Two-slot memory access stage: maps slot 0/1 onto a true-dual-port read-first
// memory, resolves intra-bundle address hazards and returns in-order responses.
module vliw_mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_WORDS  = 140001,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              s0_en,
  input  logic              s0_we,
  input  logic              s1_en,
  input  logic              s1_we,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [DATA_W-1:0] s1_wdata,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic              mem_enb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [ADDR_W-1:0] mem_addrb,
  output logic [DATA_W-1:0] mem_dia,
  output logic [DATA_W-1:0] mem_dib,
  input  logic [DATA_W-1:0] mem_doa,
  input  logic [DATA_W-1:0] mem_dob,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata0,
  output logic [DATA_W-1:0] resp_rdata1,
  output logic [1:0]        resp_err
);
  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int ENTRY_W = 2 * DATA_W + 2;

  logic accept, s0_ok, s1_ok, hazard;
  logic w0_r1, r0_w1, w0_w1;

  logic              infl_valid_reg, ld0_reg, ld1_reg, sel0_dob_reg, fwd1_reg;
  logic [DATA_W-1:0] wdata0_reg;
  logic [1:0]        err_reg;

  logic [ENTRY_W-1:0] fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg, occupancy;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic [DATA_W-1:0]  push_r0, push_r1;
  logic               push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit is computed from registered state only, so a same-cycle pop cannot raise it.
  assign occupancy = count_reg + CNT_W'(infl_valid_reg);
  assign req_ready = !rst && (occupancy < CNT_W'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;

  // Range checks come first: an out-of-range slot never takes part in a hazard.
  assign s0_ok  = s0_en && (s0_addr < ADDR_W'(MEM_WORDS));
  assign s1_ok  = s1_en && (s1_addr < ADDR_W'(MEM_WORDS));
  assign hazard = s0_ok && s1_ok && (s0_addr == s1_addr);
  assign w0_r1  = hazard && s0_we && !s1_we;
  assign r0_w1  = hazard && !s0_we && s1_we;
  assign w0_w1  = hazard && s0_we && s1_we;

  always_comb begin
    mem_ena   = accept && s0_ok && !(r0_w1 || w0_w1);
    mem_enb   = accept && s1_ok && !w0_r1;
    mem_wea   = mem_ena && s0_we;
    mem_web   = mem_enb && s1_we;
    mem_addra = mem_ena ? s0_addr  : '0;
    mem_addrb = mem_enb ? s1_addr  : '0;
    mem_dia   = mem_wea ? s0_wdata : '0;
    mem_dib   = mem_web ? s1_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_valid_reg <= 1'b0;
      ld0_reg        <= 1'b0;
      ld1_reg        <= 1'b0;
      sel0_dob_reg   <= 1'b0;
      fwd1_reg       <= 1'b0;
      wdata0_reg     <= '0;
      err_reg        <= '0;
    end else begin
      infl_valid_reg <= accept;
      if (accept) begin
        ld0_reg      <= s0_ok && !s0_we;
        ld1_reg      <= s1_ok && !s1_we;
        sel0_dob_reg <= r0_w1;
        fwd1_reg     <= w0_r1;
        wdata0_reg   <= s0_wdata;
        err_reg      <= {s1_en && !s1_ok, s0_en && !s0_ok};
      end
    end
  end

  // Read-first memory: in R0/W1 port B returns the pre-write word for slot 0.
  assign push_r0    = ld0_reg ? (sel0_dob_reg ? mem_dob : mem_doa) : '0;
  assign push_r1    = ld1_reg ? (fwd1_reg ? wdata0_reg : mem_dob) : '0;
  assign push_entry = {push_r0, push_r1, err_reg};
  assign push       = infl_valid_reg;
  assign pop        = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  assign head_entry = fifo_mem[rd_ptr_reg];
  assign resp_valid = !rst && (count_reg != '0);

  always_comb begin
    resp_rdata0 = '0;
    resp_rdata1 = '0;
    resp_err    = '0;
    if (resp_valid) begin
      resp_rdata0 = head_entry[ENTRY_W-1 -: DATA_W];
      resp_rdata1 = head_entry[DATA_W+1 -: DATA_W];
      resp_err    = head_entry[1:0];
    end
  end
endmodule
